instruction_fetch_unit: RTL and testbench

Initiator side of the program-memory read interface for the multicycle RISC-V core. It owns the PC, drives the byte address into the combinational program ROM, and latches the returned word into an instruction register. It presents that word to decode with a valid/ready handshake and accepts PC redirects from branch/jump resolution. It flags any fetch outside the ROM window.

---
 rtl/instruction_fetch_unit_pkg.sv | 15 +
 rtl/instruction_fetch_unit_fetch_addr_check.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, default text base, PC step.
// Combinational only; no latency or backpressure of its own.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/instruction_fetch_unit_fetch_addr_check.sv
// Decides whether a PC may be fetched: word aligned and inside the ROM window.
// Purely combinational, zero latency, no backpressure.
module fetch_addr_check
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  legal
);

  // One extra bit so a pc below the base shows up as a negative offset
  // and a window reaching the top of the address space still compares.
  localparam logic [DATA_WIDTH:0] WINDOW_BYTES =
    (DATA_WIDTH+1)'(MEMORY_DEPTH) * (DATA_WIDTH+1)'(PC_INC);

  logic [DATA_WIDTH:0] offset;

  always_comb begin
    offset = {1'b0, pc} - {1'b0, RESET_PC};
    legal  = (pc[1:0] == 2'b00) && !offset[DATA_WIDTH] && (offset < WINDOW_BYTES);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program-memory fetch initiator: PC, instruction register, valid/ready to decode.
// start->valid in 2 cycles; instr_out/instr_pc hold while instr_ready=0, redirects kill in-flight work.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  fetch_fault,
  output logic [DATA_WIDTH-1:0] fault_pc
);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic [DATA_WIDTH-1:0] instr_out_nxt;
  logic [DATA_WIDTH-1:0] instr_pc_nxt;
  logic [DATA_WIDTH-1:0] fault_pc_nxt;
  logic                  fault_nxt;
  logic                  pc_legal;

  fetch_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .RESET_PC    (RESET_PC)
  ) u_addr_check (
    .pc   (pc),
    .legal(pc_legal)
  );

  assign imem_address = pc;
  assign instr_valid  = (state == VALID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    instr_out_nxt = instr_out;
    instr_pc_nxt  = instr_pc;
    fault_nxt     = fetch_fault;
    fault_pc_nxt  = fault_pc;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_nxt = redirect_target;
        end else if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // A redirect discards the word on the bus and refetches from the target.
        if (redirect_valid) begin
          pc_nxt = redirect_target;
        end else if (pc_legal) begin
          instr_out_nxt = imem_instruction;
          instr_pc_nxt  = pc;
          pc_nxt        = pc + DATA_WIDTH'(PC_INC);
          state_nxt     = VALID;
        end else begin
          fault_nxt    = 1'b1;
          fault_pc_nxt = pc;
          state_nxt    = FAULT;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          state_nxt = FETCH;
        end else if (instr_ready) begin
          state_nxt = FETCH;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= RESET_PC;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else begin
      pc          <= pc_nxt;
      instr_out   <= instr_out_nxt;
      instr_pc    <= instr_pc_nxt;
      fetch_fault <= fault_nxt;
      fault_pc    <= fault_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: address-table vectors, directed
// corner sequences, and randomized ready/redirect traffic against a transaction-level model.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] rom [DEPTH];
  logic [31:0] rom_off;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(DEPTH),
    .RESET_PC    (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc)
  );

  // Combinational program ROM; outside the window it returns a recognisable junk pattern.
  assign rom_off = imem_address - BASE;
  assign imem_instruction = ((imem_address[1:0] == 2'b00) && (rom_off < 32'(4 * DEPTH)))
                            ? rom[rom_off[6:2]] : (32'hBAD0_0000 ^ imem_address);

  function automatic bit model_legal(logic [31:0] a);
    longint unsigned v;
    longint unsigned lo;
    v  = 64'(a);
    lo = 64'(BASE);
    return ((v % 64'd4) == 64'd0) && (v >= lo) && (v < lo + 64'd4 * 64'(DEPTH));
  endfunction

  function automatic logic [31:0] rom_word(logic [31:0] a);
    if (!model_legal(a)) return 32'hBAD0_0000 ^ a;
    return rom[int'((a - BASE) >> 2)];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    start           = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    step();
    step();
    reset = 1'b1;
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic        exp_valid;
    logic [31:0] exp_out;
    logic [31:0] exp_ipc;
    logic        exp_fault;
    logic [31:0] exp_fault_pc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          delivered;
    logic [31:0] last_pc;
    logic [31:0] nxt;
    logic [31:0] prev_out;
    logic [31:0] prev_ipc;
    logic        prev_valid;
    logic        prev_ready;
    logic        prev_redir;
    logic        first;

    for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
    rom[0] = 32'h0000_0513;

    vecs[0] = '{BASE,          1'b1, rom[0],  BASE,          1'b0, 32'h0};
    vecs[1] = '{32'h0040_0040, 1'b1, rom[16], 32'h0040_0040, 1'b0, 32'h0};
    vecs[2] = '{32'h0040_007C, 1'b1, rom[31], 32'h0040_007C, 1'b0, 32'h0};
    vecs[3] = '{32'h0040_0080, 1'b0, 32'h0,   BASE,          1'b1, 32'h0040_0080};
    vecs[4] = '{32'h003F_FFFC, 1'b0, 32'h0,   BASE,          1'b1, 32'h003F_FFFC};
    vecs[5] = '{32'h0040_0001, 1'b0, 32'h0,   BASE,          1'b1, 32'h0040_0001};
    vecs[6] = '{32'h0040_007E, 1'b0, 32'h0,   BASE,          1'b1, 32'h0040_007E};
    vecs[7] = '{32'hFFFF_FFFC, 1'b0, 32'h0,   BASE,          1'b1, 32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0000, 1'b0, 32'h0,   BASE,          1'b1, 32'h0000_0000};

    // Reset values, first fetch and latency
    do_reset();
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_out", instr_out, 32'h0);
    check("rst_ipc", instr_pc, BASE);
    check("rst_addr", imem_address, BASE);
    check1("rst_fault", fetch_fault, 1'b0);
    check("rst_fault_pc", fault_pc, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_fetch_addr", imem_address, BASE);
    check1("t1_fetch_valid", instr_valid, 1'b0);
    step();
    check1("t1_valid", instr_valid, 1'b1);
    check("t1_out", instr_out, 32'h0000_0513);
    check("t1_ipc", instr_pc, BASE);

    // Backpressure hold, then the next sequential instruction
    for (int i = 0; i < 5; i++) begin
      step();
      check1("t2_hold_valid", instr_valid, 1'b1);
      check("t2_hold_out", instr_out, 32'h0000_0513);
      check("t2_hold_ipc", instr_pc, BASE);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check1("t2_drop_valid", instr_valid, 1'b0);
    step();
    check1("t2_valid", instr_valid, 1'b1);
    check("t2_ipc", instr_pc, BASE + 32'h4);
    check("t2_out", instr_out, rom[1]);

    // Redirect together with ready in VALID
    redirect_valid  = 1'b1;
    redirect_target = BASE + 32'h10;
    instr_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check1("t3_drop_valid", instr_valid, 1'b0);
    check("t3_addr", imem_address, BASE + 32'h10);
    step();
    check1("t3_valid", instr_valid, 1'b1);
    check("t3_ipc", instr_pc, BASE + 32'h10);
    check("t3_out", instr_out, rom[4]);

    // Table of fetch addresses: redirect in IDLE, then start
    foreach (vecs[k]) begin
      do_reset();
      redirect_valid  = 1'b1;
      redirect_target = vecs[k].pc;
      step();
      redirect_valid = 1'b0;
      check1("tbl_idle_valid", instr_valid, 1'b0);
      check("tbl_idle_addr", imem_address, vecs[k].pc);
      start = 1'b1;
      step();
      start = 1'b0;
      check("tbl_fetch_addr", imem_address, vecs[k].pc);
      step();
      check1("tbl_valid", instr_valid, vecs[k].exp_valid);
      check("tbl_out", instr_out, vecs[k].exp_out);
      check("tbl_ipc", instr_pc, vecs[k].exp_ipc);
      check1("tbl_fault", fetch_fault, vecs[k].exp_fault);
      check("tbl_fault_pc", fault_pc, vecs[k].exp_fault_pc);
    end

    // Run off the end of the window with ready tied high
    do_reset();
    instr_ready = 1'b1;
    start       = 1'b1;
    step();
    start     = 1'b0;
    delivered = 0;
    last_pc   = 32'h0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (fetch_fault) break;
      if (instr_valid) begin
        check("t4_out", instr_out, rom_word(instr_pc));
        last_pc = instr_pc;
        delivered++;
      end
    end
    check1("t4_fault", fetch_fault, 1'b1);
    check("t4_delivered", 32'(delivered), 32'(DEPTH));
    check("t4_last_pc", last_pc, 32'h0040_007C);
    check("t4_fault_pc", fault_pc, 32'h0040_0080);
    start           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = BASE;
    for (int c = 0; c < 3; c++) begin
      step();
      check1("t4_stuck_valid", instr_valid, 1'b0);
      check1("t4_stuck_fault", fetch_fault, 1'b1);
    end
    check("t4_stuck_fault_pc", fault_pc, 32'h0040_0080);
    check("t4_stuck_addr", imem_address, 32'h0040_0080);
    start          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;

    // Misaligned redirect from VALID
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    redirect_valid  = 1'b1;
    redirect_target = BASE + 32'h2;
    step();
    redirect_valid = 1'b0;
    step();
    check1("t5_fault", fetch_fault, 1'b1);
    check("t5_fault_pc", fault_pc, BASE + 32'h2);
    check("t5_out", instr_out, rom[0]);
    check1("t5_valid", instr_valid, 1'b0);

    // Asynchronous reset in the middle of VALID
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check1("t6_valid", instr_valid, 1'b0);
    check("t6_addr", imem_address, BASE);
    check1("t6_fault", fetch_fault, 1'b0);
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_fetch_addr", imem_address, BASE);
    step();
    check1("t6_valid2", instr_valid, 1'b1);
    check("t6_ipc", instr_pc, BASE);
    check("t6_out", instr_out, rom[0]);

    // Randomized traffic: next delivered PC is the latest redirect target, else previous + 4
    for (int r = 0; r < 6; r++) begin
      do_reset();
      start = 1'b1;
      step();
      start      = 1'b0;
      nxt        = BASE;
      first      = 1'b1;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_redir = 1'b0;
      prev_out   = 32'h0;
      prev_ipc   = 32'h0;
      for (int c = 0; c < 400; c++) begin
        if (fetch_fault) begin
          check("rnd_fault_pc", fault_pc, nxt);
          check1("rnd_fault_legal", model_legal(nxt), 1'b0);
          check1("rnd_fault_valid", instr_valid, 1'b0);
          break;
        end
        if (!first) begin
          if (!prev_valid && !prev_redir) check1("rnd_progress", instr_valid, 1'b1);
          if (prev_valid && (prev_ready || prev_redir)) check1("rnd_drop", instr_valid, 1'b0);
          if (prev_valid && !prev_ready && !prev_redir) begin
            check1("rnd_hold_valid", instr_valid, 1'b1);
            check("rnd_hold_out", instr_out, prev_out);
            check("rnd_hold_ipc", instr_pc, prev_ipc);
          end
        end
        first       = 1'b0;
        instr_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 15))
          0:       redirect_target = BASE + 32'(4 * $urandom_range(0, 31)) + 32'h2;
          1:       redirect_target = BASE + 32'h80;
          2:       redirect_target = BASE - 32'h4;
          default: redirect_target = BASE + 32'(4 * $urandom_range(0, 31));
        endcase
        if (instr_valid && instr_ready) begin
          check("rnd_ipc", instr_pc, nxt);
          check("rnd_out", instr_out, rom_word(instr_pc));
          check1("rnd_legal", model_legal(instr_pc), 1'b1);
          nxt = nxt + 32'h4;
        end
        if (redirect_valid) nxt = redirect_target;
        prev_valid = instr_valid;
        prev_ready = instr_ready;
        prev_redir = redirect_valid;
        prev_out   = instr_out;
        prev_ipc   = instr_pc;
        step();
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
